// File: rtl/tracker_pkg.sv
// Shared constants and helpers for the per-second activity tracker.
package tracker_pkg;

    localparam int unsigned SS_MAX         = 59;
    localparam int unsigned MM_MAX         = 99;
    localparam int unsigned CUR_W          = 8;
    localparam int unsigned DEFAULT_THRESH = 32;
    // Half-period of the 1 Hz divider in 100 MHz cycles.
    localparam int unsigned DIV_FREQ       = 50_000_000;

    function automatic logic [CUR_W-1:0] sat_inc_cur(input logic [CUR_W-1:0] v);
        return (v == '1) ? v : v + CUR_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge pulse generator.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q, sync2_q, prev_q, primed_q;
    logic prev_d;

    // Once armed high by reset, prev only drops after both synchroniser stages hold a real
    // low sample, so a level already high at reset release never looks like a new edge.
    always_comb begin
        prev_d = sync2_q;
        if (prev_q) begin
            prev_d = ~primed_q | sync1_q | sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b1;
            primed_q <= 1'b0;
        end else begin
            sync1_q  <= d_i;
            sync2_q  <= sync1_q;
            prev_q   <= prev_d;
            primed_q <= 1'b1;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/second_tick_activity_tracker.sv
// Per-second step statistics and MM:SS elapsed time driven by a synchronised 1 Hz clock.
module second_tick_activity_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned THRESH = DEFAULT_THRESH,
    parameter int unsigned HACT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sec_clk_in,
    input  logic              step_in,
    input  logic              clear,
    output logic              sec_tick,
    output logic [STEP_W-1:0] step_total,
    output logic [7:0]        steps_last_sec,
    output logic [HACT_W-1:0] high_act_secs,
    output logic [5:0]        elapsed_ss,
    output logic [6:0]        elapsed_mm
);

    logic              sec_edge, step_edge;
    logic [CUR_W-1:0]  cur_q, cur_d, sls_q, sls_d, captured;
    logic [STEP_W-1:0] total_q, total_d;
    logic [HACT_W-1:0] hact_q, hact_d;
    logic [5:0]        ss_q, ss_d;
    logic [6:0]        mm_q, mm_d;
    logic              tick_q;

    sync_edge_detect u_sec_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sec_clk_in),
        .rise_o (sec_edge)
    );

    sync_edge_detect u_step_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (step_in),
        .rise_o (step_edge)
    );

    always_comb begin
        // A step coinciding with the second boundary belongs to the second just ending.
        captured = step_edge ? sat_inc_cur(cur_q) : cur_q;
        cur_d    = cur_q;
        sls_d    = sls_q;
        total_d  = total_q;
        hact_d   = hact_q;
        ss_d     = ss_q;
        mm_d     = mm_q;
        if (clear) begin
            cur_d   = '0;
            sls_d   = '0;
            total_d = '0;
            hact_d  = '0;
            ss_d    = '0;
            mm_d    = '0;
        end else begin
            if (step_edge && total_q != '1) begin
                total_d = total_q + STEP_W'(1);
            end
            if (sec_edge) begin
                cur_d = '0;
                sls_d = captured;
                if (captured >= CUR_W'(THRESH) && hact_q != '1) begin
                    hact_d = hact_q + HACT_W'(1);
                end
                if (ss_q == 6'(SS_MAX)) begin
                    ss_d = '0;
                    mm_d = (mm_q == 7'(MM_MAX)) ? '0 : mm_q + 7'(1);
                end else begin
                    ss_d = ss_q + 6'(1);
                end
            end else if (step_edge) begin
                cur_d = sat_inc_cur(cur_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            sls_q   <= '0;
            total_q <= '0;
            hact_q  <= '0;
            ss_q    <= '0;
            mm_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            sls_q   <= sls_d;
            total_q <= total_d;
            hact_q  <= hact_d;
            ss_q    <= ss_d;
            mm_q    <= mm_d;
            tick_q  <= sec_edge;
        end
    end

    assign sec_tick       = tick_q;
    assign step_total     = total_q;
    assign steps_last_sec = sls_q;
    assign high_act_secs  = hact_q;
    assign elapsed_ss     = ss_q;
    assign elapsed_mm     = mm_q;

endmodule

// File: tb/tb_second_tick_activity_tracker.sv
// Scoreboard bench: stimulus pushes expected per-second results, a monitor pops them on sec_tick.
module tb_second_tick_activity_tracker;

    localparam int THRESH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sec_clk_in = 1'b1;
    logic step_in = 1'b1;
    logic clear = 1'b0;

    logic        sec_tick, sec_tick4;
    logic [15:0] step_total, high_act_secs, hact4;
    logic [3:0]  step_total4;
    logic [7:0]  steps_last_sec, sls4;
    logic [5:0]  elapsed_ss, ss4;
    logic [6:0]  elapsed_mm, mm4;

    second_tick_activity_tracker #(.STEP_W(16), .THRESH(THRESH), .HACT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sec_clk_in     (sec_clk_in),
        .step_in        (step_in),
        .clear          (clear),
        .sec_tick       (sec_tick),
        .step_total     (step_total),
        .steps_last_sec (steps_last_sec),
        .high_act_secs  (high_act_secs),
        .elapsed_ss     (elapsed_ss),
        .elapsed_mm     (elapsed_mm)
    );

    second_tick_activity_tracker #(.STEP_W(4), .THRESH(THRESH), .HACT_W(16)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .sec_clk_in     (sec_clk_in),
        .step_in        (step_in),
        .clear          (clear),
        .sec_tick       (sec_tick4),
        .step_total     (step_total4),
        .steps_last_sec (sls4),
        .high_act_secs  (hact4),
        .elapsed_ss     (ss4),
        .elapsed_mm     (mm4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tick_cyc;
        int sls;
        int total;
        int total4;
        int hact;
        int ss;
        int mm;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int m_cur = 0, m_sls = 0, m_total = 0, m_total4 = 0, m_hact = 0, m_ss = 0, m_mm = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_tick"}, int'(sec_tick), 0);
        check({name, "_total"}, int'(step_total), 0);
        check({name, "_sls"}, int'(steps_last_sec), 0);
        check({name, "_hact"}, int'(high_act_secs), 0);
        check({name, "_ss"}, int'(elapsed_ss), 0);
        check({name, "_mm"}, int'(elapsed_mm), 0);
        check({name, "_dut4"}, int'(sec_tick4) + int'(step_total4) + int'(sls4) + int'(hact4)
              + int'(ss4) + int'(mm4), 0);
    endtask

    task automatic model_zero();
        m_cur = 0; m_sls = 0; m_total = 0; m_total4 = 0; m_hact = 0; m_ss = 0; m_mm = 0;
    endtask

    task automatic model_step();
        if (m_total < 65535) m_total++;
        if (m_total4 < 15) m_total4++;
        if (m_cur < 255) m_cur++;
    endtask

    task automatic step_pulse();
        step_in = 1'b1;
        model_step();
        repeat (4) @(negedge clk);
        step_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_pulse();
    endtask

    task automatic sec_pulse(input bit with_step);
        exp_t e;
        if (with_step) model_step();
        m_sls = m_cur;
        if (m_sls >= THRESH && m_hact < 65535) m_hact++;
        if (m_ss == 59) begin
            m_ss = 0;
            m_mm = (m_mm == 99) ? 0 : m_mm + 1;
        end else begin
            m_ss++;
        end
        m_cur = 0;
        e = '{cyc + 3, m_sls, m_total, m_total4, m_hact, m_ss, m_mm};
        q.push_back(e);
        sec_clk_in = 1'b1;
        if (with_step) step_in = 1'b1;
        repeat (2) @(negedge clk);
        sec_clk_in = 1'b0;
        step_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sec_tick) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_tick: sec_tick=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("tick_latency", cyc, e.tick_cyc);
                check("steps_last_sec", int'(steps_last_sec), e.sls);
                check("step_total", int'(step_total), e.total);
                check("step_total_w4", int'(step_total4), e.total4);
                check("high_act_secs", int'(high_act_secs), e.hact);
                check("elapsed_ss", int'(elapsed_ss), e.ss);
                check("elapsed_mm", int'(elapsed_mm), e.mm);
            end
        end
    end

    initial begin
        // Reset with both inputs already high: release must not create edges.
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_zero("release_high");
        end
        sec_clk_in = 1'b0;
        step_in = 1'b0;
        repeat (4) @(negedge clk);

        steps(5);
        sec_pulse(1'b0);

        steps(32);
        sec_pulse(1'b0);
        steps(31);
        sec_pulse(1'b0);

        steps(3);
        sec_pulse(1'b1);
        sec_pulse(1'b0);

        steps(300);
        sec_pulse(1'b0);
        wait_drain();

        // Clear held over a step edge: statistics zero, the step is dropped.
        steps(10);
        clear = 1'b1;
        step_in = 1'b1;
        repeat (4) @(negedge clk);
        clear = 1'b0;
        step_in = 1'b0;
        model_zero();
        @(negedge clk);
        check_zero("after_clear");
        repeat (3) @(negedge clk);
        step_pulse();
        sec_pulse(1'b0);
        wait_drain();

        for (int i = 0; i < 6000; i++) sec_pulse(1'b0);
        wait_drain();
        check("wrap_ss", int'(elapsed_ss), m_ss);
        check("wrap_mm", int'(elapsed_mm), m_mm);

        // Reset mid-second discards the partial count.
        steps(2);
        step_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_zero();
        step_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        steps(2);
        sec_pulse(1'b0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/second_tick_activity_tracker.md
Name: second_tick_activity_tracker

Overview:
- Consumer of the 1 Hz square wave produced by the fitness-tracker clock divider.
- Synchronises that slow clock and the raw step input into the 100 MHz system domain, then derives a one-cycle per-second tick.
- Maintains step statistics for the display/mode logic: total steps, steps in the last second, high-activity seconds, and elapsed MM:SS.

Parameters:
- STEP_W, 16: width of the total-step counter.
- THRESH, 32: steps in one second at or above which that second counts as high-activity (1..255).
- HACT_W, 16: width of the high-activity-seconds counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- sec_clk_in  in  1  1 Hz square wave from the divider; each rising edge marks one second.
- step_in  in  1  raw step level from the pedometer source; each rising edge is one step.
- clear  in  1  synchronous clear of all statistics, single-cycle or level.
- sec_tick  out  1  one-cycle pulse per detected second boundary.
- step_total  out  STEP_W  total steps since reset/clear; saturates at all-ones.
- steps_last_sec  out  8  steps counted in the most recently completed second.
- high_act_secs  out  HACT_W  count of completed seconds with steps >= THRESH; saturates.
- elapsed_ss  out  6  seconds, 0..59.
- elapsed_mm  out  7  minutes, 0..99.

Behaviour:
- Reset (rst_n low, asynchronous): all counters and outputs = 0; sec_tick = 0.
  - Synchroniser flops = 0.
  - Edge-detect "previous" flops = 1, so an input already high at release does not produce a spurious edge.
- Synchronisers: 2-flop synchroniser per input, then rising-edge detect (sync2 & ~prev).
- Latency: input rise sampled at edge k -> edge detected combinationally after edge k+1 -> sec_tick high in cycle after edge k+2, i.e. 3 clk cycles.
  - Step edges use the same pipeline depth.
- Per-second accumulator cur_cnt (8 bit): increments on each step edge; saturates at 255.
- On a second edge (same clock edge that asserts sec_tick):
  - steps_last_sec <= cur_cnt, plus 1 if a step edge coincides (saturating at 255).
  - cur_cnt <= 0.
  - high_act_secs increments if the captured value >= THRESH; saturates.
  - elapsed_ss increments; 59 -> 0 with elapsed_mm increment; mm 99 -> 0 with ss 0 (wraps, no flag).
- Simultaneous step and second edge: the step belongs to the second just ending. It counts in steps_last_sec and step_total; cur_cnt restarts at 0.
- step_total increments on every step edge; saturates at 2^STEP_W-1. Saturation does not stall cur_cnt.
- clear:
  - Zeros step_total, steps_last_sec, high_act_secs, elapsed_ss, elapsed_mm and cur_cnt on the next edge.
  - Has priority over simultaneous step/second edges, which are dropped.
  - sec_tick still pulses if an edge coincides; synchronisers are unaffected.
- Reset mid-second: partial cur_cnt is discarded; no tick is generated by reset release.
- All outputs are registered; none are combinational from inputs.

Decomposition:
- Shared package tracker_pkg holds:
  - SS_MAX = 59, MM_MAX = 99;
  - CUR_W = 8;
  - default THRESH = 32;
  - DIV_FREQ constant (50_000_000 half-period), for benches scaling the divider.
- One sub-module: sync_edge_detect.
  - 2-flop synchroniser plus rising-edge pulse; async active-low reset; "prev" flop resets to 1.
  - Instantiated twice: sec_clk_in and step_in.
- Top module contains counters and saturation logic only.

Test Plan:
- Reset release with sec_clk_in = 1 and step_in = 1 held -> no sec_tick, all outputs 0 for 10 cycles.
- 5 step pulses (4 cycles high, 4 low) then a sec_clk_in rise -> sec_tick exactly 3 cycles after the rise, 1 cycle wide; steps_last_sec = 5, step_total = 5, elapsed_ss = 1, high_act_secs = 0.
- THRESH = 32: 32 steps in second 1, 31 in second 2 -> high_act_secs = 1 after both ticks; steps_last_sec = 31; step_total = 63.
- Step rise and sec rise on the same cycle after 3 prior steps -> steps_last_sec = 4; next second with no steps -> steps_last_sec = 0.
- 300 steps in one second -> steps_last_sec = 255, step_total = 300; 6000 ticks -> ss 59 -> 0 with mm 99 -> 0 wrap; STEP_W = 4 with 20 steps -> step_total = 15.
- clear asserted on the same cycle as a step edge after 10 steps -> all statistics 0 next cycle, step dropped. rst_n low mid-second -> immediate zeros, and the next tick reports only post-reset steps.
